// File: rtl/digit_scan_pkg.sv
// Shared constants for the digit cascade / scan display slice.
// Glyphs are {g,f,e,d,c,b,a}, active-high.
package digit_scan_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/digit_cascade_scan_if.sv
// Bundle between the upstream digit counter and the scan stage.
// master drives count inputs; slave presents the display outputs.
interface digit_cascade_scan_if #(
  parameter int DIGITS = 4
);
  import digit_scan_pkg::*;

  logic [DIGIT_W-1:0]        nums;
  logic                      cout;
  logic                      clr;
  logic [6:0]                seg;
  logic [DIGITS-1:0]         an;
  logic                      ovf;
  logic [DIGIT_W*DIGITS-1:0] value;

  modport master (
    output nums, cout, clr,
    input  seg, an, ovf, value
  );

  modport slave (
    input  nums, cout, clr,
    output seg, an, ovf, value
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex digit to 7-segment glyph decoder.
// Every 4-bit code decodes to its hex glyph.
module seg7_decode
  import digit_scan_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [6:0]         seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/digit_cascade_scan.sv
// Upper-digit carry cascade plus multiplexed 7-segment scan.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module digit_cascade_scan
  import digit_scan_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int RADIX    = 16,
  parameter int SCAN_DIV = 4
) (
  input logic clk,
  input logic rst,
  digit_cascade_scan_if.slave bus
);

  localparam int IW = $clog2(DIGITS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(RADIX - 1);

  typedef logic [DIGIT_W-1:0] dig_t;

  dig_t            dig_q [1:DIGITS-1];
  dig_t            dig_d [1:DIGITS-1];
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  dig_t            sel;
  logic [6:0]      glyph;
  logic            blank_sel;
  logic            carry;

  // One cout pulse ripples through the whole chain on the same edge.
  always_comb begin
    carry = bus.cout;
    for (int k = 1; k < DIGITS; k++) begin
      dig_d[k] = dig_q[k];
      if (carry)
        dig_d[k] = (dig_q[k] == DMAX) ? '0 : dig_q[k] + 1'b1;
      carry = carry && (dig_q[k] == DMAX);
    end
    ovf_d = ovf_q | carry;
    if (bus.clr) begin
      for (int k = 1; k < DIGITS; k++)
        dig_d[k] = '0;
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    sel = bus.nums;
    for (int k = 1; k < DIGITS; k++)
      if (idx_q == IW'(k))
        sel = dig_q[k];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              zero_above;

  // Digit k blanks only when it and everything above it are zero.
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (dig_q[k] == '0);
      blank[k]   = zero_above;
    end
    blank_sel = blank[idx_q];
  end
`else
  assign blank_sel = 1'b0;
`endif

  seg7_decode u_dec (
    .digit_i (sel),
    .seg_o   (glyph)
  );

  always_comb begin
    seg_d = blank_sel ? SEG_BLANK : glyph;
    an_d  = DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k < DIGITS; k++)
        dig_q[k] <= '0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '0;
    end else begin
      for (int k = 1; k < DIGITS; k++)
        dig_q[k] <= dig_d[k];
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  always_comb begin
    bus.value = '0;
    bus.value[DIGIT_W-1:0] = bus.nums;
    for (int k = 1; k < DIGITS; k++)
      bus.value[k*DIGIT_W +: DIGIT_W] = dig_q[k];
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_digit_cascade_scan.sv
// Scoreboard bench for digit_cascade_scan (DIGITS=4, RADIX=16, SCAN_DIV=4).
module tb_digit_cascade_scan;

  localparam int DIGITS   = 4;
  localparam int RADIX    = 16;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  digit_cascade_scan_if #(.DIGITS(DIGITS)) bus ();

  digit_cascade_scan #(
    .DIGITS   (DIGITS),
    .RADIX    (RADIX),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [11:0] up;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Model: upper digits as one integer count, scan from cycle count.
  int cnt = 0;
  bit mov = 0;
  int cyc = 0;
  int up  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int idx, input int n);
    int v;
    if (idx == 0) return glyph[n];
    v = cnt >> (4 * (idx - 1));
`ifdef LEADING_ZERO_BLANK_EN
    if (v == 0) return 7'h00;
`endif
    return glyph[v % RADIX];
  endfunction

  task automatic drive(input int n, input bit c, input bit cl);
    exp_t e;
    int   idx;
    bus.nums = n[3:0];
    bus.cout = c;
    bus.clr  = cl;
    idx      = (cyc / SCAN_DIV) % DIGITS;
    e.an     = '0;
    e.an[idx] = 1'b1;
    e.seg    = exp_seg(idx, n);
    if (cl) begin
      cnt = 0;
      mov = 0;
    end else if (c) begin
      if (cnt == 4095) begin
        cnt = 0;
        mov = 1;
      end else begin
        cnt++;
      end
    end
    e.up  = 12'(cnt);
    e.ovf = mov;
    cyc++;
    q.push_back(e);
  endtask

  task automatic step(input int n, input bit c, input bit cl);
    @(negedge clk);
    drive(n, c, cl);
  endtask

  task automatic count_up(input int n);
    repeat (n) begin
      step(up, up == RADIX - 1, 0);
      up = (up + 1) % RADIX;
    end
  endtask

  task automatic pulse(input int n);
    repeat (n) step(0, 1, 0);
    up = 0;
  endtask

  task automatic vcheck(input string name, input int exp, input bit eovf);
    step(up, 0, 0);
    #1;
    chk(name, int'(bus.value), exp);
    chk({name, "_ovf"}, int'(bus.ovf), int'(eovf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_seg", int'(bus.seg), 0);
    chk("rst_an", int'(bus.an), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    chk("rst_upper", int'(bus.value[15:4]), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    mov = 0;
    cyc = 0;
    up  = 0;
    drive(0, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an", int'(bus.an), int'(e.an));
      chk("seg", int'(bus.seg), int'(e.seg));
      chk("upper", int'(bus.value[15:4]), int'(e.up));
      chk("ovf", int'(bus.ovf), int'(e.ovf));
    end
  end

  initial begin
    bus.nums = '0;
    bus.cout = 1'b0;
    bus.clr  = 1'b0;
    #2;
    chk("init_seg", int'(bus.seg), 0);
    chk("init_an", int'(bus.an), 0);
    chk("init_ovf", int'(bus.ovf), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0);

    count_up(16);
    vcheck("cnt16", 16'h0010, 0);
    count_up(240);
    vcheck("cnt256", 16'h0100, 0);

    step(0, 0, 1);
    pulse(4095);
    vcheck("preload", 16'hFFF0, 0);
    count_up(16);
    vcheck("wrap", 16'h0000, 1);
    count_up(5);
    vcheck("ovf_sticky", 16'h0005, 1);

    step(0, 0, 1);
    pulse(16'h23);
    vcheck("pre_clr", 16'h0230, 0);
    step(15, 1, 1);
    vcheck("clr_wins", 16'h0000, 0);

    count_up(37);
    do_reset();
    count_up(3);

    step(0, 0, 1);
    pulse(16'h123);
    up = 4;
    repeat (20) step(4, 0, 0);
    vcheck("scan1234", 16'h1234, 0);

    step(0, 0, 1);
    pulse(16'h5);
    repeat (20) step(0, 0, 0);
    vcheck("scan0050", 16'h0050, 0);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 15), $urandom_range(0, 3) == 0,
           $urandom_range(0, 63) == 0);
      if (i == 700) do_reset();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
